// File: rtl/fetch_ctrl.sv
// fetch_ctrl: front-end fetch sequencer. Owns the fetch PC, issues one aligned
//   FETCH_WIDTH-instruction request at a time to the I-cache, and forwards each
//   returned packet to fetch_buffer with a per-lane valid mask.
// Latency: icache_resp_valid in cycle N -> inst_valid in cycle N+1. Redirect in
//   cycle N -> buffer_flush in cycle N+1.
// Backpressure: requests are held off while buffer_full is high; responses are
//   never stalled (buffer_full guarantees room for a whole packet).
// Ports:
//   clock, reset                       clock and synchronous active-high reset
//   redirect_valid/redirect_pc         backend redirect and its target
//   buffer_full                        fetch_buffer cannot take a packet
//   icache_req_valid/ready/addr        request channel (valid is combinational)
//   icache_resp_valid/data             response channel, one per accepted request
//   inst_value/inst_valid/inst_pc      registered packet to fetch_buffer
//   buffer_flush                       registered one-cycle flush pulse
module fetch_ctrl #(
  parameter int              FETCH_WIDTH = 4,
  parameter int              XLEN        = 32,
  parameter int              INST_WIDTH  = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          redirect_valid,
  input  logic [XLEN-1:0]               redirect_pc,
  input  logic                          buffer_full,
  output logic                          icache_req_valid,
  input  logic                          icache_req_ready,
  output logic [XLEN-1:0]               icache_req_addr,
  input  logic                          icache_resp_valid,
  input  logic [FETCH_WIDTH*INST_WIDTH-1:0] icache_resp_data,
  output logic [FETCH_WIDTH*INST_WIDTH-1:0] inst_value,
  output logic [FETCH_WIDTH-1:0]        inst_valid,
  output logic [XLEN-1:0]               inst_pc,
  output logic                          buffer_flush
);

  localparam int OFF_W     = $clog2(FETCH_WIDTH);
  localparam int ALIGN_LSB = OFF_W + 2;
  localparam logic [XLEN-1:0] PKT_BYTES = XLEN'(FETCH_WIDTH * 4);

  // REQ: may issue a request. WAIT: live request outstanding.
  // DROP: request outstanding whose response is stale and must be discarded.
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                          state_q;
  logic [XLEN-1:0]                 pc_q;
  logic [XLEN-1:0]                 req_base_q;
  logic [OFF_W-1:0]                req_off_q;
  logic [FETCH_WIDTH*INST_WIDTH-1:0] inst_value_q;
  logic [FETCH_WIDTH-1:0]          inst_valid_q;
  logic [XLEN-1:0]                 inst_pc_q;
  logic                            buffer_flush_q;

  logic [XLEN-1:0]                 aligned_pc;
  logic                            req_hs;
  logic [FETCH_WIDTH-1:0]          lane_mask;

  // Byte-offset bits of the redirect target carry no information.
  logic unused_redirect_lsb;
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  assign aligned_pc       = {pc_q[XLEN-1:ALIGN_LSB], {ALIGN_LSB{1'b0}}};
  assign icache_req_valid = !reset && (state_q == ST_REQ) && !buffer_full && !redirect_valid;
  assign icache_req_addr  = aligned_pc;
  assign req_hs           = icache_req_valid && icache_req_ready;

  // Lanes below the entry offset of the request belong to addresses before the
  // fetch target (only non-zero on the first packet after a redirect).
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_mask[i] = (i >= int'(req_off_q));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_REQ;
      pc_q           <= RESET_PC;
      req_base_q     <= '0;
      req_off_q      <= '0;
      inst_value_q   <= '0;
      inst_valid_q   <= '0;
      inst_pc_q      <= '0;
      buffer_flush_q <= 1'b0;
    end else begin
      // Delivery and flush are single-cycle pulses.
      inst_valid_q   <= '0;
      buffer_flush_q <= 1'b0;

      if (redirect_valid) begin
        pc_q           <= {redirect_pc[XLEN-1:2], 2'b00};
        buffer_flush_q <= 1'b1;
        unique case (state_q)
          // A response arriving with the redirect is simply discarded, so no
          // request is left outstanding and DROP is not needed.
          ST_WAIT: state_q <= icache_resp_valid ? ST_REQ : ST_DROP;
          ST_DROP: state_q <= ST_DROP;
          default: state_q <= ST_REQ;
        endcase
      end else begin
        unique case (state_q)
          ST_REQ: begin
            if (req_hs) begin
              req_base_q <= aligned_pc;
              req_off_q  <= pc_q[ALIGN_LSB-1:2];
              pc_q       <= aligned_pc + PKT_BYTES;
              state_q    <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (icache_resp_valid) begin
              inst_value_q <= icache_resp_data;
              inst_pc_q    <= req_base_q;
              inst_valid_q <= lane_mask;
              state_q      <= ST_REQ;
            end
          end
          ST_DROP: begin
            if (icache_resp_valid) begin
              state_q <= ST_REQ;
            end
          end
          default: state_q <= ST_REQ;
        endcase
      end
    end
  end

  assign inst_value   = inst_value_q;
  assign inst_valid   = inst_valid_q;
  assign inst_pc      = inst_pc_q;
  assign buffer_flush = buffer_flush_q;

endmodule
